reg_pipe_chain: RTL
===================

REG_PIPE_CHAIN -- requirements
Module: reg_pipe_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits; legal range is 1..64.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of register stages; legal range is 1..16.
REQ-003 The block SHALL have parameter RESET_VAL, default 0, of WIDTH bits, giving the stage data value loaded at reset and on flush.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port rst_n: input, 1 bit, synchronous active-low reset.
REQ-007 Port flush: input, 1 bit, synchronous clear of all stage valid flags.
REQ-008 Port in_valid: input, 1 bit, upstream data valid.
REQ-009 Port in_ready: output, 1 bit, the block accepts data this cycle.
REQ-010 Port in_data: input, WIDTH bits, upstream data.
REQ-011 Port out_valid: output, 1 bit, last stage holds valid data.
REQ-012 Port out_ready: input, 1 bit, downstream accepts data.
REQ-013 Port out_data: output, WIDTH bits, last-stage data register.
REQ-014 Port wire_out: output, WIDTH bits, pure combinational copy of in_data with zero latency.
REQ-015 Port occupancy: output, $clog2(DEPTH+1) bits, count of valid stages.

Function
REQ-016 The block SHALL hold DEPTH stages, each with a valid flag v[i] and a data register d[i]; stage 0 is the input stage and stage DEPTH-1 is the output stage.
REQ-017 Readiness SHALL be rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready and rdy[i] = ~v[i] | rdy[i+1]; in_ready SHALL equal rdy[0] & ~flush & rst_n.
REQ-018 A transfer in SHALL occur when in_valid & in_ready: d[0] <= in_data and v[0] <= 1.
REQ-019 Stage i+1 SHALL load d[i] and v[i] whenever rdy[i+1]; stage 0 SHALL load v[0] <= 0 when rdy[0] is set and no transfer in occurs.
REQ-020 Stages not ready SHALL hold both data and valid (stall); data SHALL never be dropped or duplicated.
REQ-021 With out_ready held high, latency from accept to out_valid SHALL be DEPTH cycles, and throughput SHALL be 1 word per cycle.
REQ-022 A transfer out SHALL occur when out_valid & out_ready; out_valid SHALL equal v[DEPTH-1] and out_data SHALL equal d[DEPTH-1].
REQ-023 A stalled pipeline SHALL compact: an empty stage SHALL accept from its predecessor even while later stages stall.
REQ-024 occupancy SHALL equal the popcount of v[0..DEPTH-1] as registered, in the range 0..DEPTH.
REQ-025 Full condition: with occupancy = DEPTH and out_ready = 0, in_ready SHALL be 0.
REQ-026 Simultaneous transfer in and out when full: with out_ready = 1, in_ready SHALL be 1 combinationally, and occupancy SHALL remain DEPTH.
REQ-027 On flush = 1, on the next edge all v[i] SHALL be 0 and all d[i] SHALL be RESET_VAL; flush SHALL override a concurrent in_valid, whose word is not accepted.
REQ-028 wire_out SHALL track in_data regardless of reset, flush or handshake state.
REQ-029 For DEPTH = 1, the block SHALL behave as a single register slice with the same rules.

Reset
REQ-030 While rst_n = 0 at a rising edge, all v[i] SHALL clear to 0 and all d[i] SHALL load RESET_VAL.
REQ-031 After reset: out_valid = 0, out_data = RESET_VAL, occupancy = 0, in_ready = 1 once rst_n = 1.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight words with no partial output.
REQ-033 Reset SHALL take precedence over flush.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=8'h00)
REQ-034 Streaming: inputs 8'h11,22,33,44 on consecutive cycles with out_ready=1 -> out_valid first rises 4 cycles after the 8'h11 accept; out_data shows 11,22,33,44 back-to-back.
REQ-035 Backpressure: out_ready=0 with 6 offered words -> 4 accepted, in_ready=0, occupancy=4; then out_ready=1 -> the 4 words emerge in order and the remaining 2 are accepted.
REQ-036 Full with simultaneous in and out: occupancy=4, in_valid=1, out_ready=1 -> one word in and one out per cycle, occupancy stays 4.
REQ-037 Flush: 3 words in flight plus flush=1 with in_valid=1 carrying 8'hAA -> next cycle occupancy=0, out_valid=0, 8'hAA is never output.
REQ-038 Reset mid-operation: rst_n=0 for 1 cycle with occupancy=2 -> occupancy=0, out_data=8'h00; wire_out keeps following in_data throughout.
REQ-039 Bubble compaction: feed 8'h01, idle, 8'h02 with out_ready=0 for 6 cycles -> occupancy=2; release -> 01 then 02 on consecutive cycles.

Source files
------------

// File: rtl/reg_pipe_chain_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe_chain_if
// Brief    : Upstream/downstream valid-ready bundle for reg_pipe_chain, plus
//            the zero-latency data tap and the stage occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_pipe_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int c_occ_w = $clog2(DEPTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [WIDTH-1:0]   wire_out;
  logic [c_occ_w-1:0] occupancy;

  // Environment side: produces upstream words and consumes downstream words.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, wire_out, occupancy
  );

  // Pipeline side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, wire_out, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/reg_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe_chain
// Brief    : DEPTH-stage valid/ready register pipeline with per-stage ready
//            so that bubbles collapse while the output is stalled. Flush and
//            reset empty every stage and reload data with RESET_VAL.
// Revision : 1.0 - initial release
// ============================================================================
module reg_pipe_chain #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  reg_pipe_chain_if.slave  pipe
);
  localparam int c_occ_w = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]   r_v;
  logic [WIDTH-1:0]   r_d [DEPTH];
  logic [DEPTH-1:0]   w_rdy;
  logic               w_in_ready;
  logic               w_take;
  logic [c_occ_w-1:0] w_occ;

  // Ready ripples back from the output: a stage can load if it is empty or
  // if everything downstream of it can move this cycle.
  always_comb begin
    w_rdy = '0;
    w_rdy[DEPTH-1] = ~r_v[DEPTH-1] | pipe.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_rdy[i] = ~r_v[i] | w_rdy[i+1];
    end
  end

  // Flush and reset refuse the upstream word so it is never captured.
  assign w_in_ready = w_rdy[0] & ~flush & rst_n;
  assign w_take     = pipe.in_valid & w_in_ready;

  // Stage advance: every ready stage copies its predecessor, stalled stages hold.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RESET_VAL;
      end
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= w_take;
        if (w_take) begin
          r_d[0] <= pipe.in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
        end
      end
    end
  end

  // Occupancy is the population count of the registered valid flags.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + c_occ_w'(r_v[i]);
    end
  end

  assign pipe.in_ready  = w_in_ready;
  assign pipe.out_valid = r_v[DEPTH-1];
  assign pipe.out_data  = r_d[DEPTH-1];
  assign pipe.wire_out  = pipe.in_data;
  assign pipe.occupancy = w_occ;

endmodule
`default_nettype wire
